iter_collector: RTL and testbench

Batch sequencer and result collector between the Mandelbrot engines and the colour LUT. It launches the NUM_ENGINES engines on a row segment and captures each engine's iteration count as it finishes. Once the whole batch is complete it presents the batch as one valid/ready word whose per-engine iteration array feeds the LUT's iteration inputs directly. It then advances across the frame in raster order.

---
 rtl/iter_collector.sv | 179 +++++++++++++++++
 tb/tb_iter_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_collector.sv
// iter_collector: launches NUM_ENGINES Mandelbrot engines per row segment, collects their iteration
// counts and hands each complete batch to the colour LUT. Optional batch watchdog: ENGINE_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | no frame in progress, waiting for start
// S_RUN  | engines launched, capturing per-engine results
// S_HOLD | batch complete, out_valid held until out_ready
module iter_collector #(
   parameter int ITERATIONS_WIDTH = 32,
   parameter int NUM_ENGINES      = 8,
   parameter int H_RES            = 640,
   parameter int V_RES            = 480,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   output logic                                         eng_start,
   output logic [$clog2(H_RES)-1:0]                     eng_x,
   output logic [$clog2(V_RES)-1:0]                     eng_y,
   input  logic [NUM_ENGINES-1:0]                       eng_done,
   input  logic [NUM_ENGINES-1:0][ITERATIONS_WIDTH-1:0] eng_iter,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [NUM_ENGINES-1:0][ITERATIONS_WIDTH-1:0] out_iter,
   output logic                                         out_last,
   output logic                                         busy,
   output logic                                         frame_done,
   output logic                                         timeout_err
);

   localparam int XW = $clog2(H_RES);
   localparam int YW = $clog2(V_RES);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

   state_t                                       state_q, state_d;
   logic [NUM_ENGINES-1:0][ITERATIONS_WIDTH-1:0] slots_q, slots_d;
   logic [NUM_ENGINES-1:0]                       filled_q, filled_d, cap;
   logic [XW-1:0]                                eng_x_q, eng_x_d;
   logic [YW-1:0]                                eng_y_q, eng_y_d;
   logic [XW:0]                                  x_sum;
   logic eng_start_q, eng_start_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic busy_q, busy_d, frame_done_q, frame_done_d;
   logic accept, timeout;

`ifdef ENGINE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          timeout_err_q, timeout_err_d;
   assign timeout     = (state_q == S_RUN) && (timer_q == '0);
   assign timeout_err = timeout_err_q;
`else
   assign timeout     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign accept = out_valid_q && out_ready;
   assign cap    = (state_q == S_RUN) ? (eng_done & ~filled_q) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         slots_q      <= '0;
         filled_q     <= '0;
         eng_x_q      <= '0;
         eng_y_q      <= '0;
         eng_start_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef ENGINE_TIMEOUT_EN
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         slots_q      <= slots_d;
         filled_q     <= filled_d;
         eng_x_q      <= eng_x_d;
         eng_y_q      <= eng_y_d;
         eng_start_q  <= eng_start_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef ENGINE_TIMEOUT_EN
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (((filled_q | cap) == '1) || timeout) state_d = S_HOLD;
         S_HOLD:  if (accept) state_d = out_last_q ? S_IDLE : S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      slots_d      = slots_q;
      filled_d     = filled_q;
      eng_x_d      = eng_x_q;
      eng_y_d      = eng_y_q;
      eng_start_d  = 1'b0;
      frame_done_d = 1'b0;
      x_sum        = {1'b0, eng_x_q} + (XW+1)'(NUM_ENGINES);
`ifdef ENGINE_TIMEOUT_EN
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               slots_d     = '0;
               filled_d    = '0;
               eng_x_d     = '0;
               eng_y_d     = '0;
               eng_start_d = 1'b1;
`ifdef ENGINE_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end
         end
         S_RUN: begin
            for (int i = 0; i < NUM_ENGINES; i++) begin
               if (cap[i]) slots_d[i] = eng_iter[i];
               // a stalled engine reports zero iterations rather than stale data
               if (timeout && !(filled_q[i] || cap[i])) slots_d[i] = '0;
            end
            filled_d = filled_q | cap;
`ifdef ENGINE_TIMEOUT_EN
            if (timeout) timeout_err_d = 1'b1;
`endif
         end
         S_HOLD: begin
            if (accept) begin
               if (out_last_q) begin
                  frame_done_d = 1'b1;
               end else begin
                  filled_d    = '0;
                  eng_start_d = 1'b1;
                  if (x_sum == (XW+1)'(H_RES)) begin
                     eng_x_d = '0;
                     eng_y_d = eng_y_q + YW'(1);
                  end else begin
                     eng_x_d = x_sum[XW-1:0];
                  end
               end
            end
         end
         default: ;
      endcase
      out_valid_d = (state_d == S_HOLD);
      busy_d      = (state_d != S_IDLE);
      out_last_d  = (state_d == S_HOLD) && (eng_x_q == XW'(H_RES - NUM_ENGINES))
                    && (eng_y_q == YW'(V_RES - 1));
`ifdef ENGINE_TIMEOUT_EN
      // down-counter reloads with every launch; terminal count forces the batch out
      timer_d = timer_q;
      if (eng_start_d)                        timer_d = TW'(TIMEOUT_CYCLES - 1);
      else if (state_q == S_RUN && !timeout)  timer_d = timer_q - TW'(1);
`endif
   end

   assign eng_start  = eng_start_q;
   assign eng_x      = eng_x_q;
   assign eng_y      = eng_y_q;
   assign out_valid  = out_valid_q;
   assign out_iter   = slots_q;
   assign out_last   = out_last_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_iter_collector.sv
// Self-checking bench for iter_collector on a 16x2 frame with 8 engines (4 batches per frame).
module tb_iter_collector;
   localparam int IW = 32;
   localparam int NE = 8;
   localparam int HR = 16;
   localparam int VR = 2;
   localparam int TO = 50;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic eng_start, out_valid, out_last, busy, frame_done, timeout_err;
   logic [3:0] eng_x;
   logic       eng_y;
   logic [NE-1:0]         eng_done = '0;
   logic [NE-1:0][IW-1:0] eng_iter = '0;
   logic [NE-1:0][IW-1:0] out_iter;
   int checks = 0, errors = 0;

   iter_collector #(.ITERATIONS_WIDTH(IW), .NUM_ENGINES(NE), .H_RES(HR), .V_RES(VR),
                    .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
      .eng_done(eng_done), .eng_iter(eng_iter), .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_last(out_last), .busy(busy), .frame_done(frame_done),
      .timeout_err(timeout_err));

   always #5 clk = ~clk;

   task automatic do_reset();
      start = 0; out_ready = 0; eng_done = '0; eng_iter = '0; rst = 1;
      @(negedge clk); @(negedge clk);
      rst = 0;
   endtask

   task automatic start_frame();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic test_reset();
      logic [8:0] vals;
      do_reset();
      vals = {eng_start, out_valid, out_last, busy, frame_done, timeout_err, eng_x[0], eng_y, |out_iter};
      checks++;
      if (vals !== 9'b0 || eng_x !== 4'd0) begin
         errors++; $display("FAIL reset_values got %b x=%0d want all zero", vals, eng_x);
      end
      start_frame();
      eng_done = 8'hFF; for (int i = 0; i < NE; i++) eng_iter[i] = $urandom_range(1, 1000);
      @(negedge clk) eng_done = '0; out_ready = 1;
      @(negedge clk) out_ready = 0; eng_done = 8'h03;
      @(negedge clk) eng_done = '0;
      #2 rst = 1;
      #1;
      vals = {eng_start, out_valid, out_last, busy, frame_done, timeout_err, 1'b0, eng_y, |out_iter};
      checks++;
      if (vals !== 9'b0 || eng_x !== 4'd0) begin
         errors++; $display("FAIL reset_mid_run got %b x=%0d want all zero", vals, eng_x);
      end
      @(negedge clk) rst = 0;
   endtask

   task automatic test_out_of_order();
      logic [NE-1:0][IW-1:0] exp;
      do_reset();
      start_frame();
      checks++;
      if (eng_start !== 1 || busy !== 1) begin
         errors++; $display("FAIL start_latency eng_start=%b busy=%b want 1 1", eng_start, busy);
      end
      for (int i = NE - 1; i >= 0; i--) begin
         exp[i] = 10 + i;
         eng_done = '0; eng_done[i] = 1'b1; eng_iter = '0; eng_iter[i] = 10 + i;
         @(negedge clk);
         checks++;
         if (out_valid !== (i == 0)) begin
            errors++; $display("FAIL ooo_valid_timing bit=%0d got %b want %b", i, out_valid, i == 0);
         end
      end
      eng_done = '0;
      checks++;
      if (out_iter !== exp || eng_x !== 0 || eng_y !== 0 || out_last !== 0) begin
         errors++; $display("FAIL ooo_data got %h x=%0d y=%0d last=%b want %h 0 0 0",
                            out_iter, eng_x, eng_y, out_last, exp);
      end
   endtask

   task automatic test_duplicate();
      do_reset();
      start_frame();
      eng_done = 8'h7F; for (int i = 0; i < NE; i++) eng_iter[i] = 124;
      @(negedge clk) eng_done = 8'h08; eng_iter[3] = 5;
      @(negedge clk) eng_done = 8'h80; eng_iter[3] = 124;
      checks++;
      if (out_valid !== 0) begin
         errors++; $display("FAIL dup_early_valid got %b want 0", out_valid);
      end
      @(negedge clk) eng_done = 8'hFF; for (int i = 0; i < NE; i++) eng_iter[i] = 99;
      checks++;
      if (out_valid !== 1) begin
         errors++; $display("FAIL dup_valid got %b want 1", out_valid);
      end
      @(negedge clk) eng_done = '0;
      for (int i = 0; i < NE; i++) begin
         checks++;
         if (out_iter[i] !== 124) begin
            errors++; $display("FAIL dup_slot%0d got %0d want 124", i, out_iter[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [NE-1:0][IW-1:0] exp;
      int bad;
      do_reset();
      start_frame();
      eng_done = 8'hFF;
      for (int i = 0; i < NE; i++) begin eng_iter[i] = $urandom; exp[i] = eng_iter[i]; end
      @(negedge clk);
      checks++;
      if (out_valid !== 1 || out_iter !== exp) begin
         errors++; $display("FAIL simult_capture valid=%b got %h want %h", out_valid, out_iter, exp);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         eng_done = NE'($urandom); start = $urandom_range(0, 1);
         for (int i = 0; i < NE; i++) eng_iter[i] = $urandom;
         @(negedge clk);
         if (out_valid !== 1 || out_iter !== exp || eng_start !== 0) bad++;
      end
      eng_done = '0; start = 0;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL backpressure_stable got %0d bad cycles want 0", bad);
      end
      out_ready = 1;
      @(negedge clk) out_ready = 0;
      checks++;
      if (eng_start !== 1 || out_valid !== 0 || eng_x !== 8 || eng_y !== 0) begin
         errors++; $display("FAIL bp_release eng_start=%b valid=%b x=%0d y=%0d want 1 0 8 0",
                            eng_start, out_valid, eng_x, eng_y);
      end
   endtask

   task automatic test_full_frame();
      logic [NE-1:0][IW-1:0] exp;
      logic [NE-1:0] fmask, m;
      int n, ex, ey;
      do_reset();
      start_frame();
      for (int b = 0; b < HR * VR / NE; b++) begin
         ex = (b * NE) % HR; ey = (b * NE) / HR;
         checks++;
         if (eng_start !== 1 || eng_x !== ex[3:0] || eng_y !== ey[0]) begin
            errors++; $display("FAIL frame_launch b=%0d eng_start=%b x=%0d y=%0d want 1 %0d %0d",
                               b, eng_start, eng_x, eng_y, ex, ey);
         end
         fmask = '0; exp = '0; n = 0;
         while (fmask != '1 && n < 100) begin
            m = NE'($urandom & $urandom);
            for (int i = 0; i < NE; i++) begin
               eng_iter[i] = $urandom;
               if (m[i] && !fmask[i]) exp[i] = eng_iter[i];
            end
            fmask |= m; eng_done = m; start = ($urandom_range(0, 2) == 0);
            @(negedge clk); n++;
         end
         eng_done = '0; start = 0;
         checks++;
         if (out_valid !== 1 || out_iter !== exp || out_last !== (b == 3)) begin
            errors++; $display("FAIL frame_batch b=%0d valid=%b last=%b got %h want %h",
                               b, out_valid, out_last, out_iter, exp);
         end
         out_ready = 1;
         @(negedge clk) out_ready = 0;
      end
      checks++;
      if (frame_done !== 1 || busy !== 0 || out_valid !== 0 || eng_start !== 0) begin
         errors++; $display("FAIL frame_done_pulse fd=%b busy=%b valid=%b es=%b want 1 0 0 0",
                            frame_done, busy, out_valid, eng_start);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 0 || busy !== 0) begin
         errors++; $display("FAIL frame_done_width fd=%b busy=%b want 0 0", frame_done, busy);
      end
   endtask

`ifdef ENGINE_TIMEOUT_EN
   task automatic test_timeout();
      logic [NE-1:0][IW-1:0] exp;
      int cnt;
      do_reset();
      start_frame();
      exp = '0; cnt = 0;
      while (out_valid !== 1 && cnt < 200) begin
         eng_done = '0; eng_iter = '0;
         if (cnt < 6) begin
            eng_done[cnt] = 1'b1; eng_iter[cnt] = $urandom_range(1, 9999); exp[cnt] = eng_iter[cnt];
         end
         @(negedge clk); cnt++;
      end
      eng_done = '0;
      checks++;
      if (cnt != TO || out_iter !== exp || timeout_err !== 1) begin
         errors++; $display("FAIL timeout_hold cycles=%0d err=%b got %h want %0d 1 %h",
                            cnt, timeout_err, out_iter, TO, exp);
      end
      for (int b = 1; b < 4; b++) begin
         out_ready = 1;
         @(negedge clk) out_ready = 0; eng_done = '1;
         @(negedge clk) eng_done = '0;
      end
      out_ready = 1;
      @(negedge clk) out_ready = 0;
      checks++;
      if (timeout_err !== 1 || frame_done !== 1) begin
         errors++; $display("FAIL timeout_sticky err=%b fd=%b want 1 1", timeout_err, frame_done);
      end
      start_frame();
      checks++;
      if (timeout_err !== 0 || eng_start !== 1) begin
         errors++; $display("FAIL timeout_clear err=%b es=%b want 0 1", timeout_err, eng_start);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_out_of_order();
      test_duplicate();
      test_backpressure();
      test_full_frame();
`ifdef ENGINE_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
